// File: rtl/hazard_forward_unit.sv
// Tnew/Tuse hazard and forwarding controller: shadow scoreboard of in-flight
// destinations, D-stage stall, D/E operand forward selects and MDU busy window.
module hazard_forward_unit #(
    parameter int NSTAGE  = 3,
    parameter int AW      = 5,
    parameter int TW      = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    localparam int SELW   = $clog2(NSTAGE + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   d_rs,
    input  logic [AW-1:0]   d_rt,
    input  logic            d_rs_used,
    input  logic            d_rt_used,
    input  logic [TW-1:0]   d_rs_tuse,
    input  logic [TW-1:0]   d_rt_tuse,
    input  logic            d_wr_en,
    input  logic [AW-1:0]   d_wr_addr,
    input  logic [TW-1:0]   d_tnew,
    input  logic            d_mdu_use,
    input  logic            d_mdu_start,
    input  logic            d_mdu_is_div,
    output logic            stall,
    output logic [SELW-1:0] d_fwd_rs,
    output logic [SELW-1:0] d_fwd_rt,
    output logic [SELW-1:0] e_fwd_rs,
    output logic [SELW-1:0] e_fwd_rt,
    output logic            mdu_busy
);

    localparam int MAXLAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    // Scoreboard entry k shadows the destination of the instruction in stage k.
    logic          sb_valid [1:NSTAGE];
    logic [AW-1:0] sb_addr  [1:NSTAGE];
    logic [TW-1:0] sb_tnew  [1:NSTAGE];

    logic [AW-1:0] e_rs;
    logic [AW-1:0] e_rt;
    logic          e_rs_used;
    logic          e_rt_used;
    logic          e_mdu_start;
    logic          e_mdu_is_div;
    logic [CW-1:0] mdu_cnt;

    logic            rs_hit, rt_hit, e_rs_hit, e_rt_hit;
    logic [SELW-1:0] rs_sel, rt_sel, e_rs_sel, e_rt_sel;
    logic [TW-1:0]   rs_tnew, rt_tnew, e_rs_tnew, e_rt_tnew;
    logic            stall_rs, stall_rt, stall_mdu;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                sb_valid[k] <= 1'b0;
                sb_addr[k]  <= '0;
                sb_tnew[k]  <= '0;
            end
            e_rs         <= '0;
            e_rt         <= '0;
            e_rs_used    <= 1'b0;
            e_rt_used    <= 1'b0;
            e_mdu_start  <= 1'b0;
            e_mdu_is_div <= 1'b0;
            mdu_cnt      <= '0;
        end else begin
            for (int k = 2; k <= NSTAGE; k++) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_addr[k]  <= sb_addr[k-1];
                sb_tnew[k]  <= (sb_tnew[k-1] != '0) ? sb_tnew[k-1] - TW'(1) : '0;
            end
            if (stall) begin
                sb_valid[1]  <= 1'b0;
                sb_addr[1]   <= '0;
                sb_tnew[1]   <= '0;
                e_rs         <= '0;
                e_rt         <= '0;
                e_rs_used    <= 1'b0;
                e_rt_used    <= 1'b0;
                e_mdu_start  <= 1'b0;
                e_mdu_is_div <= 1'b0;
            end else begin
                sb_valid[1]  <= d_wr_en && (d_wr_addr != '0);
                sb_addr[1]   <= d_wr_addr;
                sb_tnew[1]   <= d_tnew;
                e_rs         <= d_rs;
                e_rt         <= d_rt;
                e_rs_used    <= d_rs_used;
                e_rt_used    <= d_rt_used;
                e_mdu_start  <= d_mdu_start;
                e_mdu_is_div <= d_mdu_is_div;
            end
            // The start sits in E for one cycle before the countdown begins.
            if (e_mdu_start)
                mdu_cnt <= e_mdu_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
            else if (mdu_cnt != '0)
                mdu_cnt <= mdu_cnt - CW'(1);
        end
    end

    // Scan oldest to youngest so the youngest (lowest k) match wins.
    always_comb begin
        rs_hit    = 1'b0;
        rt_hit    = 1'b0;
        e_rs_hit  = 1'b0;
        e_rt_hit  = 1'b0;
        rs_sel    = '0;
        rt_sel    = '0;
        e_rs_sel  = '0;
        e_rt_sel  = '0;
        rs_tnew   = '0;
        rt_tnew   = '0;
        e_rs_tnew = '0;
        e_rt_tnew = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (sb_valid[k] && (sb_addr[k] == d_rs) && (d_rs != '0)) begin
                rs_hit  = 1'b1;
                rs_sel  = SELW'(k);
                rs_tnew = sb_tnew[k];
            end
            if (sb_valid[k] && (sb_addr[k] == d_rt) && (d_rt != '0)) begin
                rt_hit  = 1'b1;
                rt_sel  = SELW'(k);
                rt_tnew = sb_tnew[k];
            end
        end
        // Stage 1 holds the E instruction itself, so E only looks from stage 2.
        for (int k = NSTAGE; k >= 2; k--) begin
            if (sb_valid[k] && (sb_addr[k] == e_rs) && (e_rs != '0)) begin
                e_rs_hit  = 1'b1;
                e_rs_sel  = SELW'(k);
                e_rs_tnew = sb_tnew[k];
            end
            if (sb_valid[k] && (sb_addr[k] == e_rt) && (e_rt != '0)) begin
                e_rt_hit  = 1'b1;
                e_rt_sel  = SELW'(k);
                e_rt_tnew = sb_tnew[k];
            end
        end
    end

    always_comb begin
        d_fwd_rs  = (rs_hit && (rs_tnew == '0)) ? rs_sel : '0;
        d_fwd_rt  = (rt_hit && (rt_tnew == '0)) ? rt_sel : '0;
        e_fwd_rs  = (e_rs_hit && e_rs_used && (e_rs_tnew == '0)) ? e_rs_sel : '0;
        e_fwd_rt  = (e_rt_hit && e_rt_used && (e_rt_tnew == '0)) ? e_rt_sel : '0;
        mdu_busy  = (mdu_cnt != '0);
        stall_rs  = d_rs_used && rs_hit && (rs_tnew > d_rs_tuse);
        stall_rt  = d_rt_used && rt_hit && (rt_tnew > d_rt_tuse);
        stall_mdu = d_mdu_use && (mdu_busy || e_mdu_start);
        stall     = stall_rs || stall_rt || stall_mdu;
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: table of per-cycle D-stage vectors with
// hand-derived expected outputs, plus hand-written MDU and reset sequences.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_wr_addr;
    logic       d_rs_used, d_rt_used, d_wr_en;
    logic [2:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_mdu_use, d_mdu_start, d_mdu_is_div;
    logic       stall, mdu_busy;
    logic [1:0] d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        logic [4:0] rs, rt, wr_addr;
        logic       rs_used, rt_used, wr_en;
        logic [2:0] rs_tuse, rt_tuse, tnew;
        logic       mdu_use, mdu_start, is_div;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];

    hazard_forward_unit dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
        .d_mdu_use(d_mdu_use), .d_mdu_start(d_mdu_start), .d_mdu_is_div(d_mdu_is_div),
        .stall(stall), .d_fwd_rs(d_fwd_rs), .d_fwd_rt(d_fwd_rt),
        .e_fwd_rs(e_fwd_rs), .e_fwd_rt(e_fwd_rt), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    // Expected output word: {stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, mdu_busy}
    function automatic logic [9:0] ex(input logic s, input logic [1:0] dfr, input logic [1:0] dft,
                                      input logic [1:0] efr, input logic [1:0] eft, input logic b);
        return {s, dfr, dft, efr, eft, b};
    endfunction

    function automatic vec_t ins(input logic [4:0] rs, input logic rsu, input logic [2:0] rst,
                                 input logic [4:0] rt, input logic rtu, input logic [2:0] rtt,
                                 input logic wen, input logic [4:0] wa, input logic [2:0] tn,
                                 input logic [9:0] e);
        vec_t v;
        v.rs = rs; v.rs_used = rsu; v.rs_tuse = rst;
        v.rt = rt; v.rt_used = rtu; v.rt_tuse = rtt;
        v.wr_en = wen; v.wr_addr = wa; v.tnew = tn;
        v.mdu_use = 1'b0; v.mdu_start = 1'b0; v.is_div = 1'b0;
        v.exp = e;
        return v;
    endfunction

    function automatic vec_t nop(input logic [9:0] e);
        return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endfunction

    function automatic vec_t mdu(input logic use_i, input logic start, input logic dv, input logic [9:0] e);
        vec_t v;
        v = nop(e);
        v.mdu_use = use_i; v.mdu_start = start; v.is_div = dv;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        d_rs = v.rs; d_rs_used = v.rs_used; d_rs_tuse = v.rs_tuse;
        d_rt = v.rt; d_rt_used = v.rt_used; d_rt_tuse = v.rt_tuse;
        d_wr_en = v.wr_en; d_wr_addr = v.wr_addr; d_tnew = v.tnew;
        d_mdu_use = v.mdu_use; d_mdu_start = v.mdu_start; d_mdu_is_div = v.is_div;
    endtask

    task automatic check_out(input string tag, input int idx);
        logic [9:0] e, act;
        act = {stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, mdu_busy};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s[%0d]: no expected entry queued, got %b", tag, idx, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s[%0d]: got {stall,dfrs,dfrt,efrs,efrt,busy}=%b expected %b",
                         tag, idx, act, e);
            end
        end
    endtask

    // One D-stage cycle: drive just after the edge, compare on the falling edge.
    task automatic run_vec(input vec_t v, input string tag, input int idx);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        check_out(tag, idx);
    endtask

    initial begin
        reset = 1'b0;
        drive(nop(0));
        #3;
        exp_q.push_back(10'd0);
        check_out("reset_init", 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // ALU -> branch: one stall, then forward from stage 2, E sees stage 3
        tbl.push_back(ins(1, 1, 1, 2, 1, 1, 1, 3, 1, 0));
        tbl.push_back(ins(3, 1, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0)));
        tbl.push_back(ins(3, 1, 0, 0, 0, 0, 0, 0, 0, ex(0, 2, 0, 0, 0, 0)));
        tbl.push_back(nop(ex(0, 0, 0, 3, 0, 0)));
        tbl.push_back(nop(0)); tbl.push_back(nop(0)); tbl.push_back(nop(0));
        // Load-use on rt: one stall, E forwards from stage 3
        tbl.push_back(ins(29, 1, 1, 0, 0, 0, 1, 5, 2, 0));
        tbl.push_back(ins(6, 1, 1, 5, 1, 1, 1, 7, 1, ex(1, 0, 0, 0, 0, 0)));
        tbl.push_back(ins(6, 1, 1, 5, 1, 1, 1, 7, 1, 0));
        tbl.push_back(nop(ex(0, 0, 0, 0, 3, 0)));
        tbl.push_back(nop(0)); tbl.push_back(nop(0)); tbl.push_back(nop(0));
        // Duplicate writers of $4 in stages 2 and 3: nearest wins
        tbl.push_back(ins(0, 0, 0, 0, 0, 0, 1, 4, 0, 0));
        tbl.push_back(ins(0, 0, 0, 0, 0, 0, 1, 4, 0, 0));
        tbl.push_back(nop(0));
        tbl.push_back(ins(4, 1, 0, 4, 1, 0, 0, 0, 0, ex(0, 2, 2, 0, 0, 0)));
        tbl.push_back(nop(ex(0, 0, 0, 3, 3, 0)));
        tbl.push_back(nop(0)); tbl.push_back(nop(0));
        // Writes to $0 never hazard or forward
        tbl.push_back(ins(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(ins(0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0));
        // Younger not-ready writer shadows an older ready one; tnew == tuse does not stall
        tbl.push_back(ins(0, 0, 0, 0, 0, 0, 1, 9, 0, 0));
        tbl.push_back(ins(0, 0, 0, 0, 0, 0, 1, 9, 2, 0));
        tbl.push_back(ins(9, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0));
        tbl.push_back(nop(0)); tbl.push_back(nop(0));
        // Unused operand never stalls
        tbl.push_back(ins(0, 0, 0, 0, 0, 0, 1, 10, 2, 0));
        tbl.push_back(ins(10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0)); tbl.push_back(nop(0)); tbl.push_back(nop(0));
        // mult: one cycle in E, then five busy cycles
        tbl.push_back(mdu(1, 1, 0, 0));
        tbl.push_back(nop(0));
        for (int i = 0; i < 5; i++) tbl.push_back(nop(ex(0, 0, 0, 0, 0, 1)));
        tbl.push_back(nop(0));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], "table", i);

        // div then mflo: 1 stall for the start in E, then 10 busy stalls
        run_vec(mdu(1, 1, 1, 0), "div_seq", 0);
        run_vec(mdu(1, 0, 0, ex(1, 0, 0, 0, 0, 0)), "div_seq", 1);
        for (int i = 0; i < 10; i++)
            run_vec(mdu(1, 0, 0, ex(1, 0, 0, 0, 0, 1)), "div_seq", 2 + i);
        run_vec(mdu(1, 0, 0, 0), "div_seq", 12);
        run_vec(nop(0), "div_seq", 13);

        // Reset while the divide counter is at 6 and $3 is ready in stage 1
        run_vec(mdu(1, 1, 1, 0), "rst_seq", 0);
        run_vec(nop(0), "rst_seq", 1);
        for (int i = 0; i < 3; i++) run_vec(nop(ex(0, 0, 0, 0, 0, 1)), "rst_seq", 2 + i);
        run_vec(ins(0, 0, 0, 0, 0, 0, 1, 3, 0, ex(0, 0, 0, 0, 0, 1)), "rst_seq", 5);
        begin
            vec_t mf;
            mf = ins(3, 1, 0, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 0, 1));
            mf.mdu_use = 1'b1;
            run_vec(mf, "rst_seq", 6);
            #2 reset = 1'b0;
            #1;
            exp_q.push_back(10'd0);
            check_out("rst_async", 0);
            @(posedge clk);
            #1 reset = 1'b1;
        end
        run_vec(ins(3, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rst_after", 0);
        run_vec(mdu(1, 0, 0, 0), "rst_after", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
